// File: rtl/spi_pkg.sv
// Shared SPI definitions: transmitter state encoding, default widths and mode-0 polarity.
package spi_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 3;

  // Mode 0: sclk idles low, chip select idles high.
  localparam logic SCLK_IDLE = 1'b0;
  localparam logic CS_IDLE   = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous SPI pin, with single-cycle rise/fall pulses.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  logic meta;
  logic prev;

  // Reset to the pin's idle level so releasing reset never fakes an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta  <= RST_VAL;
      level <= RST_VAL;
      prev  <= RST_VAL;
    end else begin
      meta  <= d;
      level <= meta;
      prev  <= level;
    end
  end

  assign rise_c = level & ~prev;
  assign fall_c = ~level & prev;

endmodule

// File: rtl/spi_slave_tx.sv
// SPI mode-0 slave transmitter: parallel-loaded byte buffer shifted out MSB-first on miso.
module spi_slave_tx
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              ptr_clr,
  input  logic              sclk,
  input  logic              cs,
  output logic              miso,
  output logic              miso_oe,
  output logic              busy,
  output logic              byte_done,
  output logic [ADDR_W-1:0] rd_ptr
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DATA_W - 1);

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  bit_cnt;
  logic [ADDR_W-1:0] rd_nxt;

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic unused;

  spi_sync_edge #(.RST_VAL(SCLK_IDLE)) u_sync_sclk (
    .clk    (clk),
    .rst    (rst),
    .d      (sclk),
    .level  (sclk_lvl),
    .rise_c (sclk_rise),
    .fall_c (sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(CS_IDLE)) u_sync_cs (
    .clk    (clk),
    .rst    (rst),
    .d      (cs),
    .level  (cs_lvl),
    .rise_c (cs_rise),
    .fall_c (cs_fall)
  );

  // Master samples on sclk rise, so only the falling edge matters here.
  assign unused = ^{sclk_rise, sclk_lvl, cs_rise};

  assign rd_nxt = rd_ptr + ADDR_W'(1);

  // Byte buffer; nonblocking update gives read-before-write against a same-cycle load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem <= '{default: '0};
    end else if (wr_en) begin
      mem[waddr] <= wdata;
    end
  end

  // Transmit control; every output is registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      busy      <= 1'b0;
      byte_done <= 1'b0;
      rd_ptr    <= '0;
      shreg     <= '0;
      bit_cnt   <= '0;
    end else begin
      byte_done <= 1'b0;

      if (state == IDLE && ptr_clr) begin
        rd_ptr <= '0;
      end

      if (cs_lvl) begin
        // Deselect aborts any partial byte; rd_ptr is kept so it is resent.
        state   <= IDLE;
        miso    <= 1'b0;
        miso_oe <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              state <= LOAD;
              busy  <= 1'b1;
            end
          end

          LOAD: begin
            shreg   <= mem[rd_ptr];
            bit_cnt <= CNT_TOP;
            miso    <= mem[rd_ptr][DATA_W-1];
            miso_oe <= 1'b1;
            state   <= SHIFT;
          end

          SHIFT: begin
            if (sclk_fall) begin
              if (bit_cnt != '0) begin
                shreg   <= {shreg[DATA_W-2:0], 1'b0};
                miso    <= shreg[DATA_W-2];
                bit_cnt <= bit_cnt - CNT_W'(1);
              end else begin
                // Byte boundary: advance and present the next byte's MSB at once.
                byte_done <= 1'b1;
                rd_ptr    <= rd_nxt;
                shreg     <= mem[rd_nxt];
                miso      <= mem[rd_nxt][DATA_W-1];
                bit_cnt   <= CNT_TOP;
              end
            end
          end

          default: begin
            state   <= IDLE;
            miso    <= 1'b0;
            miso_oe <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_tx.sv
// Directed bench for spi_slave_tx acting as a mode-0 SPI master with 100 ns sclk.
module tb_spi_slave_tx;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] waddr = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic              ptr_clr = 1'b0;
  logic              sclk = 1'b0;
  logic              cs = 1'b1;
  logic              miso;
  logic              miso_oe;
  logic              busy;
  logic              byte_done;
  logic [ADDR_W-1:0] rd_ptr;

  int n_tests = 0;
  int n_fail  = 0;
  int bd_cnt  = 0;

  always #5 clk = ~clk;

  spi_slave_tx #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .waddr     (waddr),
    .wdata     (wdata),
    .ptr_clr   (ptr_clr),
    .sclk      (sclk),
    .cs        (cs),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .busy      (busy),
    .byte_done (byte_done),
    .rd_ptr    (rd_ptr)
  );

  always @(negedge clk) begin
    if (rst && byte_done) bd_cnt++;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    waddr = a;
    wdata = d;
    wr_en = 1'b1;
    tick(1);
    wr_en = 1'b0;
  endtask

  task automatic pclr();
    ptr_clr = 1'b1;
    tick(1);
    ptr_clr = 1'b0;
  endtask

  task automatic cs_start();
    cs = 1'b0;
    tick(5);
  endtask

  task automatic cs_end();
    cs = 1'b1;
    tick(4);
  endtask

  // Each bit: sample miso as sclk rises, 5 clk high, 5 clk low.
  task automatic shift_bits(input int n, output logic [7:0] v);
    v = '0;
    for (int i = 0; i < n; i++) begin
      sclk = 1'b1;
      v = {v[6:0], miso};
      tick(5);
      sclk = 1'b0;
      tick(5);
    end
  endtask

  logic [7:0] v1, v2;
  logic [7:0] wv [8];
  logic [7:0] fin [4];
  int bd0;

  initial begin
    tick(3);
    chk("rst_miso", miso, 0);
    chk("rst_oe", miso_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bd", byte_done, 0);
    chk("rst_ptr", rd_ptr, 0);
    rst = 1'b1;
    tick(2);

    // Reset mid-frame, then confirm the buffer was cleared.
    wr(3'd0, 8'hA5);
    cs_start();
    shift_bits(4, v1);
    chk("pre_rst_bits", v1, 8'h0A);
    rst = 1'b0;
    tick(1);
    chk("midrst_miso", miso, 0);
    chk("midrst_oe", miso_oe, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ptr", rd_ptr, 0);
    cs = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(3);
    cs_start();
    shift_bits(8, v1);
    chk("post_rst_byte", v1, 8'h00);
    cs_end();
    chk("post_rst_ptr", rd_ptr, 1);

    // Two-byte frame with start/stop latency checks.
    pclr();
    chk("pclr_idle_a", rd_ptr, 0);
    wr(3'd0, 8'h12);
    wr(3'd1, 8'h34);
    bd0 = bd_cnt;
    cs = 1'b0;
    tick(3);
    chk("oe_lat_3", miso_oe, 0);
    tick(1);
    chk("oe_lat_4", miso_oe, 1);
    chk("msb_lat_4", miso, 0);
    tick(1);
    shift_bits(8, v1);
    chk("t2_byte0", v1, 8'h12);
    shift_bits(8, v1);
    chk("t2_byte1", v1, 8'h34);
    chk("t2_bd", bd_cnt - bd0, 2);
    chk("t2_ptr", rd_ptr, 2);
    cs = 1'b1;
    tick(2);
    chk("oe_off_2", miso_oe, 1);
    tick(1);
    chk("oe_off_3", miso_oe, 0);
    chk("busy_off_3", busy, 0);
    tick(1);

    // Nine bytes in one frame wrap the read pointer.
    wv[0] = 8'h12; wv[1] = 8'h34; wv[2] = 8'h56; wv[3] = 8'h78;
    wv[4] = 8'h9a; wv[5] = 8'hbc; wv[6] = 8'hde; wv[7] = 8'h70;
    pclr();
    chk("pclr_idle_b", rd_ptr, 0);
    for (int i = 0; i < 8; i++) wr(3'(i), wv[i]);
    bd0 = bd_cnt;
    cs_start();
    for (int i = 0; i < 9; i++) begin
      shift_bits(8, v1);
      chk($sformatf("wrap_byte%0d", i), v1, wv[i % 8]);
      chk($sformatf("wrap_ptr%0d", i), rd_ptr, (i + 1) % 8);
    end
    cs_end();
    chk("wrap_bd", bd_cnt - bd0, 9);

    // Abort after 5 bits of 0x56; sclk-fall to miso is 3 clk.
    cs_start();
    shift_bits(8, v1);
    chk("ab_byte34", v1, 8'h34);
    shift_bits(4, v1);
    chk("ab_4bits", v1, 8'h05);
    sclk = 1'b1;
    tick(5);
    sclk = 1'b0;
    tick(2);
    chk("sclk_lat_2", miso, 0);
    tick(1);
    chk("sclk_lat_3", miso, 1);
    tick(2);
    cs = 1'b1;
    tick(2);
    chk("ab_oe_2", miso_oe, 1);
    tick(1);
    chk("ab_oe_3", miso_oe, 0);
    chk("ab_ptr", rd_ptr, 2);
    tick(1);
    cs_start();
    shift_bits(8, v1);
    chk("ab_resend", v1, 8'h56);
    cs_end();
    chk("ab_ptr_after", rd_ptr, 3);

    // Write to the loading address during LOAD; ptr_clr while busy.
    cs = 1'b0;
    tick(3);
    chk("col_busy", busy, 1);
    wr(3'd3, 8'hFF);
    chk("col_oe", miso_oe, 1);
    tick(1);
    shift_bits(3, v1);
    pclr();
    chk("busy_pclr_ptr", rd_ptr, 3);
    shift_bits(5, v2);
    chk("col_old_byte", {v1[2:0], v2[4:0]}, 8'h78);
    chk("col_ptr", rd_ptr, 4);
    cs_end();
    chk("col_idle_busy", busy, 0);
    pclr();
    chk("pclr_idle_c", rd_ptr, 0);
    fin[0] = 8'h12; fin[1] = 8'h34; fin[2] = 8'h56; fin[3] = 8'hFF;
    cs_start();
    for (int i = 0; i < 4; i++) begin
      shift_bits(8, v1);
      chk($sformatf("fin_byte%0d", i), v1, fin[i]);
    end
    cs_end();
    chk("fin_ptr", rd_ptr, 4);
    chk("bd_total", bd_cnt, 19);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
